// File: rtl/mux4_pkg.sv
// Shared encodings for the mux4_1 select sequencer: FSM states and channel select codes.
package mux4_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam logic [1:0] CH_A = 2'd0;
  localparam logic [1:0] CH_B = 2'd1;
  localparam logic [1:0] CH_C = 2'd2;
  localparam logic [1:0] CH_D = 2'd3;

  function automatic logic [3:0] onehot4(input logic [1:0] ch);
    return 4'b0001 << ch;
  endfunction

endpackage

// File: rtl/mux4_sel_sched_rr_pick4.sv
// Combinational round-robin picker: first requester after 'last', wrapping d -> a.
module rr_pick4
  import mux4_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic [1:0] pick,
  output logic       any
);

  logic       found;
  logic [1:0] idx;

  always_comb begin
    pick  = CH_A;
    found = 1'b0;
    idx   = last;
    for (int i = 1; i <= 4; i++) begin
      idx = last + 2'(i);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    any = |req;
  end

endmodule

// File: rtl/mux4_sel_sched.sv
// Select sequencer for mux4_1: round-robin time-slicing of channels a..d with a
// DWELL-accept grant and a one-cycle blanking gap between grants.
module mux4_sel_sched
  import mux4_pkg::*;
#(
  parameter int DWELL = 4,
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] req,
  input  logic       ready,
  output logic       s1,
  output logic       s2,
  output logic [3:0] grant,
  output logic       sel_valid,
  output logic       busy
);

  // Handshake: while sel_valid is high the consumer signals ready; every cycle
  // with sel_valid && ready is one accepted transfer and consumes one dwell slot.

  if (DWELL < 1 || DWELL > 255) begin : g_bad_dwell
    $error("mux4_sel_sched: DWELL must be in 1..255");
  end
  if ((2 ** CNT_W) <= DWELL) begin : g_bad_cnt_w
    $error("mux4_sel_sched: CNT_W too narrow for DWELL");
  end

  state_t           state;
  logic [1:0]       cur;
  logic [1:0]       last;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       pick;
  logic             any;
  logic             release_now;

  rr_pick4 u_pick (
    .req  (req),
    .last (last),
    .pick (pick),
    .any  (any)
  );

  // Release beats a same-cycle accept; that accept still counts as taken.
  assign release_now = !en || !req[cur] || (ready && (cnt == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cur       <= CH_A;
      last      <= CH_D;
      cnt       <= '0;
      s1        <= 1'b0;
      s2        <= 1'b0;
      grant     <= 4'b0000;
      sel_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_GRANT: begin
          if (release_now) begin
            state     <= ST_GAP;
            last      <= cur;
            grant     <= 4'b0000;
            sel_valid <= 1'b0;
          end else if (ready) begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_IDLE, ST_GAP: begin
          // s1/s2 keep the old code through the gap so the mux select never glitches.
          if (en && any) begin
            state     <= ST_GRANT;
            cur       <= pick;
            cnt       <= CNT_W'(DWELL - 1);
            {s1, s2}  <= pick;
            grant     <= onehot4(pick);
            sel_valid <= 1'b1;
            busy      <= 1'b1;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          grant     <= 4'b0000;
          sel_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux4_sel_sched.sv
// Directed bench for mux4_sel_sched with DWELL=4: reset, round-robin order,
// ready stalls, request drop, long stall and enable drop/resume.
module tb_mux4_sel_sched;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] req;
  logic       ready;
  logic       s1;
  logic       s2;
  logic [3:0] grant;
  logic       sel_valid;
  logic       busy;

  int errors = 0;
  int checks = 0;

  mux4_sel_sched #(.DWELL(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req       (req),
    .ready     (ready),
    .s1        (s1),
    .s2        (s2),
    .grant     (grant),
    .sel_valid (sel_valid),
    .busy      (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst   = 1'b1;
    en    = 1'b0;
    req   = 4'b0000;
    ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    en    = 1'b0;
    req   = 4'b0000;
    ready = 1'b0;
    repeat (2) tick();
    checks++;
    if ({s1, s2, grant, sel_valid, busy} !== 8'h00) begin
      errors++;
      $display("FAIL reset_init: got s=%b%b grant=%b v=%b busy=%b, want all 0", s1, s2, grant, sel_valid, busy);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || sel_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got busy=%b v=%b, want 0 0", busy, sel_valid);
    end
    // grant b, release it, re-grant b so 'last' is b before the mid-grant reset
    en  = 1'b1;
    req = 4'b0010;
    tick();
    req = 4'b0000;
    tick();
    req = 4'b0010;
    tick();
    checks++;
    if (grant !== 4'b0010 || busy !== 1'b1 || {s1, s2} !== 2'b01) begin
      errors++;
      $display("FAIL reset_pregrant: got grant=%b busy=%b s=%b%b, want 0010 1 01", grant, busy, s1, s2);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({s1, s2, grant, sel_valid, busy} !== 8'h00) begin
      errors++;
      $display("FAIL reset_async: got s=%b%b grant=%b v=%b busy=%b, want all 0", s1, s2, grant, sel_valid, busy);
    end
    req = 4'b1111;
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (grant !== 4'b0001 || {s1, s2} !== 2'b00 || sel_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_last: got grant=%b s=%b%b v=%b, want 0001 00 1", grant, s1, s2, sel_valid);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] ch;
    apply_reset();
    en    = 1'b1;
    req   = 4'b1111;
    ready = 1'b1;
    for (int g = 0; g < 5; g++) begin
      ch = 2'(g % 4);
      for (int k = 0; k < 4; k++) begin
        tick();
        checks++;
        if (grant !== (4'b0001 << ch) || {s1, s2} !== ch || sel_valid !== 1'b1) begin
          errors++;
          $display("FAIL rr_grant g=%0d k=%0d: got grant=%b s=%b%b v=%b, want %b %b 1",
                   g, k, grant, s1, s2, sel_valid, 4'b0001 << ch, ch);
        end
      end
      tick();
      checks++;
      if (grant !== 4'b0000 || sel_valid !== 1'b0 || {s1, s2} !== ch || busy !== 1'b1) begin
        errors++;
        $display("FAIL rr_gap g=%0d: got grant=%b v=%b s=%b%b busy=%b, want 0000 0 %b 1",
                 g, grant, sel_valid, s1, s2, busy, ch);
      end
    end
  endtask

  task automatic test_ready_toggle();
    apply_reset();
    en  = 1'b1;
    req = 4'b0100;
    tick();
    checks++;
    if (grant !== 4'b0100 || {s1, s2} !== 2'b10) begin
      errors++;
      $display("FAIL tog_start: got grant=%b s=%b%b, want 0100 10", grant, s1, s2);
    end
    for (int j = 0; j < 7; j++) begin
      ready = (j % 2 == 0);
      tick();
      checks++;
      if (j < 6) begin
        if (grant !== 4'b0100 || sel_valid !== 1'b1) begin
          errors++;
          $display("FAIL tog_hold j=%0d: got grant=%b v=%b, want 0100 1", j, grant, sel_valid);
        end
      end else if (grant !== 4'b0000 || sel_valid !== 1'b0 || {s1, s2} !== 2'b10) begin
        errors++;
        $display("FAIL tog_gap: got grant=%b v=%b s=%b%b, want 0000 0 10", grant, sel_valid, s1, s2);
      end
    end
    tick();
    checks++;
    if (grant !== 4'b0100 || sel_valid !== 1'b1) begin
      errors++;
      $display("FAIL tog_regrant: got grant=%b v=%b, want 0100 1", grant, sel_valid);
    end
  endtask

  task automatic test_req_drop();
    apply_reset();
    en    = 1'b1;
    req   = 4'b0010;
    ready = 1'b1;
    tick();
    tick();
    checks++;
    if (grant !== 4'b0010 || {s1, s2} !== 2'b01) begin
      errors++;
      $display("FAIL drop_b: got grant=%b s=%b%b, want 0010 01", grant, s1, s2);
    end
    req = 4'b1100;
    tick();
    checks++;
    if (sel_valid !== 1'b0 || grant !== 4'b0000 || {s1, s2} !== 2'b01) begin
      errors++;
      $display("FAIL drop_gap: got v=%b grant=%b s=%b%b, want 0 0000 01", sel_valid, grant, s1, s2);
    end
    tick();
    checks++;
    if (grant !== 4'b0100 || {s1, s2} !== 2'b10 || sel_valid !== 1'b1) begin
      errors++;
      $display("FAIL drop_next: got grant=%b s=%b%b v=%b, want 0100 10 1", grant, s1, s2, sel_valid);
    end
  endtask

  task automatic test_stall();
    int bad;
    apply_reset();
    en    = 1'b1;
    req   = 4'b1111;
    ready = 1'b1;
    tick();
    tick();
    ready = 1'b0;
    bad   = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (grant !== 4'b0001 || sel_valid !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL stall_hold: %0d stalled cycles lost grant a, want 0", bad);
    end
    ready = 1'b1;
    tick();
    tick();
    checks++;
    if (grant !== 4'b0001) begin
      errors++;
      $display("FAIL stall_cnt: got grant=%b after 2 more accepts, want 0001", grant);
    end
    tick();
    checks++;
    if (sel_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_gap: got v=%b, want 0", sel_valid);
    end
    tick();
    checks++;
    if (grant !== 4'b0010) begin
      errors++;
      $display("FAIL stall_next: got grant=%b, want 0010", grant);
    end
  endtask

  task automatic test_enable();
    apply_reset();
    en    = 1'b1;
    req   = 4'b1111;
    ready = 1'b1;
    tick();
    tick();
    en = 1'b0;
    tick();
    checks++;
    if (sel_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL en_gap: got v=%b busy=%b, want 0 1", sel_valid, busy);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || grant !== 4'b0000) begin
      errors++;
      $display("FAIL en_idle: got busy=%b grant=%b, want 0 0000", busy, grant);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL en_stay: got busy=%b, want 0", busy);
    end
    en = 1'b1;
    tick();
    checks++;
    if (grant !== 4'b0010 || {s1, s2} !== 2'b01 || busy !== 1'b1) begin
      errors++;
      $display("FAIL en_resume: got grant=%b s=%b%b busy=%b, want 0010 01 1", grant, s1, s2, busy);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_ready_toggle();
    test_req_drop();
    test_stall();
    test_enable();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
